// File: rtl/pico_qsys_ram_arbiter.sv
// Round-robin arbiter sharing one single-port 4096x32 RAM between the PicoRV32 native bus (cpu)
// and a loader/debug master (dbg); absorbs the RAM read latency and returns a one-cycle ready.
module pico_qsys_ram_arbiter #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    input  logic              dbg_valid,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    input  logic [3:0]        dbg_wstrb,
    output logic              dbg_ready,
    output logic [31:0]       dbg_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_debugaccess,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   grant_q, grant_d;

    logic [ADDR_W-1:0] mem_address_d;
    logic [3:0]        mem_byteenable_d;
    logic              mem_chipselect_d;
    logic              mem_write_d;
    logic              mem_debugaccess_d;
    logic [31:0]       mem_writedata_d;
    logic              cpu_ready_d;
    logic              dbg_ready_d;
    logic              busy_d;

    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_wstrb;

    // Upper address bits and the base address are decoded upstream.
    logic unused_bits;
    assign unused_bits = ^{BASE_ADDR, cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                           dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    // Next-state and arbitration
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (cpu_valid || dbg_valid) begin
                    state_d = ACCESS;
                    grant_d = (cpu_valid && dbg_valid) ? ~last_q : dbg_valid;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                state_d = IDLE;
                last_d  = grant_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; the request is captured straight into the RAM controls
    always_comb begin
        sel_addr          = grant_d ? dbg_addr[ADDR_W+1:2] : cpu_addr[ADDR_W+1:2];
        sel_wdata         = grant_d ? dbg_wdata : cpu_wdata;
        sel_wstrb         = grant_d ? dbg_wstrb : cpu_wstrb;
        mem_address_d     = '0;
        mem_byteenable_d  = 4'h0;
        mem_chipselect_d  = 1'b0;
        mem_write_d       = 1'b0;
        mem_debugaccess_d = 1'b0;
        mem_writedata_d   = 32'h0;
        cpu_ready_d       = 1'b0;
        dbg_ready_d       = 1'b0;
        busy_d            = (state_d != IDLE);
        if (state_q == IDLE && state_d == ACCESS) begin
            mem_chipselect_d = 1'b1;
            mem_address_d    = sel_addr;
            if (sel_wstrb != 4'h0) begin
                mem_write_d       = 1'b1;
                mem_debugaccess_d = 1'b1;
                mem_byteenable_d  = sel_wstrb;
                mem_writedata_d   = sel_wdata;
            end else begin
                mem_byteenable_d  = 4'hF;
            end
        end
        if (state_q == ACCESS) begin
            cpu_ready_d = ~grant_q;
            dbg_ready_d = grant_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_address     <= '0;
            mem_byteenable  <= 4'h0;
            mem_chipselect  <= 1'b0;
            mem_write       <= 1'b0;
            mem_debugaccess <= 1'b0;
            mem_writedata   <= 32'h0;
            cpu_ready       <= 1'b0;
            dbg_ready       <= 1'b0;
            busy            <= 1'b0;
        end else begin
            mem_address     <= mem_address_d;
            mem_byteenable  <= mem_byteenable_d;
            mem_chipselect  <= mem_chipselect_d;
            mem_write       <= mem_write_d;
            mem_debugaccess <= mem_debugaccess_d;
            mem_writedata   <= mem_writedata_d;
            cpu_ready       <= cpu_ready_d;
            dbg_ready       <= dbg_ready_d;
            busy            <= busy_d;
        end
    end

    // RAM read data arrives during RESP, so it is steered combinationally behind ready
    assign cpu_rdata = cpu_ready ? mem_readdata : 32'h0;
    assign dbg_rdata = dbg_ready ? mem_readdata : 32'h0;
    assign mem_clken = 1'b1;

endmodule

// File: tb/tb_pico_qsys_ram_arbiter.sv
// Bench for pico_qsys_ram_arbiter: behavioural RAM, vector table, scoreboard queues per port,
// and hand-written sequences for arbitration, reset and protocol corners.
module tb_pico_qsys_ram_arbiter;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned NV     = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_valid, dbg_valid;
    logic [31:0]       cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [3:0]        cpu_wstrb, dbg_wstrb;
    logic              cpu_ready, dbg_ready;
    logic [31:0]       cpu_rdata, dbg_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write, mem_debugaccess, mem_clken, busy;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata = 32'h0;

    typedef struct {
        bit          port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        bit          is_read;
        int          cyc;
    } exp_t;

    vec_t  vecs [NV];
    exp_t  q_cpu [$];
    exp_t  q_dbg [$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    logic [31:0] ram [0:4095];

    pico_qsys_ram_arbiter #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_wstrb(dbg_wstrb),
        .dbg_ready(dbg_ready), .dbg_rdata(dbg_rdata),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_debugaccess(mem_debugaccess), .mem_writedata(mem_writedata),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with one-cycle read latency and per-byte write enables
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write && mem_debugaccess)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_port(input bit p, input logic rdy, input logic [31:0] rd);
        exp_t e;
        bit   empty;
        if (!rdy) begin
            chk(p ? "dbg_rdata_idle" : "cpu_rdata_idle", rd, 32'h0);
        end else begin
            empty = p ? (q_dbg.size() == 0) : (q_cpu.size() == 0);
            if (empty) begin
                chk(p ? "dbg_unexpected_ready" : "cpu_unexpected_ready", 32'd1, 32'd0);
            end else begin
                if (p) e = q_dbg.pop_front();
                else   e = q_cpu.pop_front();
                chk(p ? "dbg_ready_cycle" : "cpu_ready_cycle", 32'(cyc), 32'(e.cyc));
                if (e.is_read) chk(p ? "dbg_rdata" : "cpu_rdata", rd, e.data);
            end
        end
    endtask

    // Scoreboard consumer: every ready pulse must match the oldest expectation of its port
    always @(negedge clk) begin
        mon_port(1'b0, cpu_ready, cpu_rdata);
        mon_port(1'b1, dbg_ready, dbg_rdata);
        chk("one_ready_at_a_time", 32'(cpu_ready & dbg_ready), 32'h0);
    end

    task automatic drive(input bit p, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
        if (!p) begin
            cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = wd; cpu_wstrb = s;
        end else begin
            dbg_valid = 1'b1; dbg_addr = a; dbg_wdata = wd; dbg_wstrb = s;
        end
    endtask

    task automatic release_port(input bit p);
        if (!p) cpu_valid = 1'b0;
        else    dbg_valid = 1'b0;
    endtask

    task automatic push(input bit p, input logic [31:0] d, input bit rd, input int c);
        exp_t e;
        e.data = d; e.is_read = rd; e.cyc = c;
        if (!p) q_cpu.push_back(e);
        else    q_dbg.push_back(e);
    endtask

    task automatic wait_ready(input bit p, input int lim);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < lim) begin
            @(negedge clk);
            n++;
            seen = p ? dbg_ready : cpu_ready;
        end
        if (!seen) chk(p ? "dbg_ready_timeout" : "cpu_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic single(input vec_t v);
        int c;
        c = cyc;
        drive(v.port, v.addr, v.wdata, v.wstrb);
        push(v.port, v.exp_rdata, v.wstrb == 4'h0, c + 2);
        @(negedge clk);
        chk("access_cs", 32'(mem_chipselect), 32'd1);
        chk("access_addr", 32'(mem_address), 32'(v.addr[ADDR_W+1:2]));
        chk("access_write", 32'(mem_write), 32'(v.wstrb != 4'h0));
        chk("access_debugaccess", 32'(mem_debugaccess), 32'(v.wstrb != 4'h0));
        chk("access_be", 32'(mem_byteenable), (v.wstrb == 4'h0) ? 32'hF : 32'(v.wstrb));
        if (v.wstrb != 4'h0) chk("access_wdata", mem_writedata, v.wdata);
        chk("access_busy", 32'(busy), 32'd1);
        wait_ready(v.port, 4);
        chk("resp_cs", 32'(mem_chipselect), 32'd0);
        release_port(v.port);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;
        vecs[0]  = '{1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 4'hF,    32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0020, 32'hAAAA_AAAA, 4'hF,    32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0,    32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0100, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0,    32'hAA22_AAAA};
        vecs[5]  = '{1'b0, 32'h0000_3FFC, 32'h8765_4321, 4'hF,    32'h0};
        vecs[6]  = '{1'b1, 32'h0000_3FFC, 32'h0,         4'h0,    32'h8765_4321};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF,    32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0000, 32'hA1B2_C3D4, 4'b1010, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0,    32'hA1FF_C3FF};
        vecs[10] = '{1'b1, 32'h0000_4014, 32'h0,         4'h0,    32'hDEAD_BEEF};
        vecs[11] = '{1'b0, 32'h0000_0020, 32'h1234_5678, 4'b0001, 32'h0};
        vecs[12] = '{1'b1, 32'h0000_0020, 32'h0,         4'h0,    32'hAA22_AA78};

        reset = 1'b1;
        cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        dbg_valid = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_wstrb = '0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_dbg_ready", 32'(dbg_ready), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_dbg_rdata", dbg_rdata, 32'h0);
        chk("rst_cs", 32'(mem_chipselect), 32'd0);
        chk("rst_write", 32'(mem_write), 32'd0);
        chk("rst_debugaccess", 32'(mem_debugaccess), 32'd0);
        chk("rst_be", 32'(mem_byteenable), 32'h0);
        chk("rst_addr", 32'(mem_address), 32'h0);
        chk("rst_wdata", mem_writedata, 32'h0);
        chk("rst_clken", 32'(mem_clken), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < int'(NV); i++) single(vecs[i]);

        // Saturation: both ports hold valid, grants alternate on a 3-cycle cadence
        c = cyc;
        drive(1'b0, 32'h0000_0014, 32'h0, 4'h0);
        drive(1'b1, 32'h0000_3FFC, 32'h0, 4'h0);
        push(1'b0, 32'hDEAD_BEEF, 1'b1, c + 2);
        push(1'b1, 32'h8765_4321, 1'b1, c + 5);
        push(1'b0, 32'hDEAD_BEEF, 1'b1, c + 8);
        push(1'b1, 32'h8765_4321, 1'b1, c + 11);
        fork
            begin wait_ready(1'b0, 6); wait_ready(1'b0, 8); release_port(1'b0); end
            begin wait_ready(1'b1, 8); wait_ready(1'b1, 8); release_port(1'b1); end
        join
        @(negedge clk);

        // Leave cpu as the last-served port, then abort a cpu read with reset in ACCESS
        single('{1'b0, 32'h0000_0014, 32'h0, 4'h0, 32'hDEAD_BEEF});
        drive(1'b0, 32'h0000_0014, 32'h0, 4'h0);
        @(negedge clk);
        chk("abort_access_busy", 32'(busy), 32'd1);
        chk("abort_access_cs", 32'(mem_chipselect), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_no_ready", 32'(cpu_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cs", 32'(mem_chipselect), 32'd0);
        reset = 1'b0;
        release_port(1'b0);
        @(negedge clk);

        // Tie right after reset goes to cpu, dbg follows three cycles later
        c = cyc;
        drive(1'b0, 32'h0000_0014, 32'h0, 4'h0);
        drive(1'b1, 32'h0000_3FFC, 32'h0, 4'h0);
        push(1'b0, 32'hDEAD_BEEF, 1'b1, c + 2);
        push(1'b1, 32'h8765_4321, 1'b1, c + 5);
        wait_ready(1'b0, 4);
        release_port(1'b0);
        wait_ready(1'b1, 5);
        release_port(1'b1);
        @(negedge clk);

        // Early drop: valid removed during ACCESS still yields exactly one ready
        c = cyc;
        drive(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        push(1'b0, 32'hAA22_AA78, 1'b1, c + 2);
        @(negedge clk);
        release_port(1'b0);
        wait_ready(1'b0, 3);
        repeat (3) begin
            @(negedge clk);
            chk("drop_busy", 32'(busy), 32'd0);
            chk("drop_cs", 32'(mem_chipselect), 32'd0);
        end

        chk("cpu_queue_drained", 32'(q_cpu.size()), 32'd0);
        chk("dbg_queue_drained", 32'(q_dbg.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
